data_mem_responder: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 27 ++
 rtl/dm_storage_array.sv | 39 +++
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// ----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and helpers for the data-memory responder.
//   dmr_state_t : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W      : data word width in bits
//   BE_W        : number of byte lanes per word
//   addr_ok()   : true when a byte address is word aligned and inside a
//                 storage of 2^addr_w words
// ----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmr_state_t;

    function automatic logic addr_ok(input logic [WORD_W-1:0] addr, input int addr_w);
        logic [WORD_W-1:0] upper;
        upper = addr >> (addr_w + 2);
        return (addr[1:0] == 2'b00) && (upper == '0);
    endfunction

endpackage

// File: rtl/dm_storage_array.sv
// ----------------------------------------------------------------------------
// dm_storage_array
// Word-organised data storage: asynchronous read, synchronous write with
// per-byte enables. Contents are deliberately not reset.
//   clk   : write clock
//   we    : write strobe for the addressed word
//   addr  : word address
//   be    : byte-lane enables (lane i = bits [8i+7:8i])
//   wdata : write data
//   rdata : combinational read of the addressed word
// ----------------------------------------------------------------------------
module dm_storage_array
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   be,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Multi-cycle data memory for the MIPS core load/store path. Accepts one word
// request at a time over valid/ready, waits a programmable number of cycles,
// commits stores with byte enables and answers with a one-cycle response.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   req_valid : core presents a request
//   req_ready : responder idle and able to accept
//   req_write : 1 = store, 0 = load
//   req_addr  : byte address
//   req_wdata : store data
//   req_be    : store byte enables (ignored for loads)
//   rsp_valid : one-cycle response pulse (no backpressure)
//   rsp_rdata : load data, 0 for stores, errors and outside the pulse
//   rsp_err   : misaligned or out-of-range access, 0 outside the pulse
// ----------------------------------------------------------------------------
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dmr_state_t        state, state_next;
    logic [3:0]        count, count_next;
    logic              accept;
    logic              commit;

    logic              lat_write;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;

    logic              lat_ok;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    // WAIT spans the cycle after accept plus WAIT_CYCLES wait states, so the
    // counter starts at WAIT_CYCLES and RESP is entered when it reads zero.
    // This places the pulse in the cycle after edge N+WAIT_CYCLES+1 and keeps
    // req_ready low for the whole pulse.
    always_comb begin
        state_next = state;
        count_next = count;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = WAIT;
                    count_next = WAIT_INIT;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Request payload is plain data: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    assign lat_ok = addr_ok(lat_addr, ADDR_W);
    assign mem_we = commit && lat_write && lat_ok;

    dm_storage_array #(
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk   (clk),
        .we    (mem_we),
        .addr  (lat_addr[ADDR_W+1:2]),
        .be    (lat_be),
        .wdata (lat_wdata),
        .rdata (mem_rdata)
    );

    // Response registers load on the edge entering RESP and clear on every
    // other edge, so they read zero whenever rsp_valid is low. A reset during
    // RESP clears them at once; the store committed on entry is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_rdata <= (lat_ok && !lat_write) ? mem_rdata : '0;
            rsp_err   <= !lat_ok;
        end else begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int ADDR_W = 10;
    localparam int W_MAIN = 2;
    localparam int NWORDS = 1 << ADDR_W;
    localparam int N0     = 12;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        rv0, rdy0, rw0, vl0, er0;
    logic [31:0] ra0, rwd0, rd0;
    logic [3:0]  rbe0;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] m2 [NWORDS];
    logic [31:0] m0 [NWORDS];

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W_MAIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (rv0),
        .req_ready (rdy0),
        .req_write (rw0),
        .req_addr  (ra0),
        .req_wdata (rwd0),
        .req_be    (rbe0),
        .rsp_valid (vl0),
        .rsp_rdata (rd0),
        .rsp_err   (er0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, observed hang expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural memory: word-indexed arrays, byte lanes merged arithmetically.
    task automatic model(input bit sel, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] erd, output logic eer);
        logic [31:0] w;
        int          idx;
        eer = ((addr % 4) != 0) || (addr >= 32'(4 * NWORDS));
        erd = '0;
        if (!eer) begin
            idx = int'(addr / 4);
            w   = sel ? m0[idx] : m2[idx];
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                if (sel) m0[idx] = w; else m2[idx] = w;
            end else begin
                erd = w;
            end
        end
    endtask

    // One complete transaction on the WAIT_CYCLES=2 instance.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic er);
        int lat;
        bit got;
        @(negedge clk);
        req_write = wr; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        lat = 0; got = 0; rd = '0; er = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) got = 1;
        end
        check("rsp_latency", 64'(lat), 64'(W_MAIN + 1));
        rd = rsp_rdata;
        er = rsp_err;
        check("ready_low_in_resp", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check("pulse_end_valid_err_rdata", {31'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    endtask

    task automatic run(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic        eer;
        model(1'b0, wr, addr, wd, be, erd, eer);
        txn(wr, addr, wd, be, rd, er);
        check({tag, "_rdata"}, 64'(rd), 64'(erd));
        check({tag, "_err"}, 64'(er), 64'(eer));
    endtask

    logic        q_wr  [N0];
    logic [31:0] q_ad  [N0];
    logic [31:0] q_wd  [N0];
    logic [3:0]  q_be  [N0];
    logic [31:0] q_erd [N0];
    logic        q_eer [N0];

    initial begin
        logic [31:0] rd, prior;
        logic        er, bad;
        int          idx, ri, e, last_acc;
        bit          acc_now, prev_v;

        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rv0 = 1'b0; rw0 = 1'b0; ra0 = '0; rwd0 = '0; rbe0 = '0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check("reset_in", {28'd0, req_ready, rsp_valid, rsp_err, 1'b0, rsp_rdata}, {28'd0, 4'b1000, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out", {28'd0, req_ready, rsp_valid, rsp_err, 1'b0, rsp_rdata}, {28'd0, 4'b1000, 32'd0});
        check("reset_out_w0", {62'd0, rdy0, vl0}, 64'b10);

        // Fill a small pool of words with known values
        for (int i = 0; i < 16; i++)
            run("init", 1'b1, 32'(4 * i), $urandom, 4'hF, rd, er);

        // Directed store/load
        run("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
        check("st_10_err_const", 64'(er), 64'd0);
        run("ld_10", 1'b0, 32'h10, $urandom, 4'($urandom), rd, er);
        check("ld_10_const", 64'(rd), 64'hDEADBEEF);

        // Byte enables
        run("st_be", 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er);
        run("ld_be", 1'b0, 32'h10, '0, '0, rd, er);
        check("ld_be_const", 64'(rd), 64'hDE22BE44);

        // Errors
        run("ld_mis", 1'b0, 32'h12, '0, '0, rd, er);
        check("ld_mis_const", {31'd0, er, rd}, {31'd0, 1'b1, 32'd0});
        prior = m2[0];
        run("st_oor", 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, rd, er);
        check("st_oor_err_const", 64'(er), 64'd1);
        run("ld_0", 1'b0, 32'h0, '0, '0, rd, er);
        check("ld_0_unchanged", 64'(rd), 64'(prior));

        // Empty byte-enable store is legal and writes nothing
        prior = m2[1];
        run("st_be0", 1'b1, 32'h4, 32'hFFFFFFFF, 4'b0000, rd, er);
        run("ld_4", 1'b0, 32'h4, '0, '0, rd, er);
        check("ld_4_unchanged", 64'(rd), 64'(prior));

        // Reset while the store is waiting
        prior = m2[8];
        @(negedge clk);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_wait_reset_outputs", {31'd0, rsp_valid, rsp_rdata}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad = 1'b1;
        end
        check("mid_wait_no_response", 64'(bad), 64'd0);
        run("ld_20", 1'b0, 32'h20, '0, '0, rd, er);
        check("ld_20_prior", 64'(rd), 64'(prior));

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int          r;
            r = int'($urandom_range(0, 9));
            a = 32'(4 * $urandom_range(0, 15));
            if (r == 0) a = a + 32'($urandom_range(1, 3));
            if (r == 1) a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
            run("rand", 1'($urandom), a, $urandom, 4'($urandom), rd, er);
        end

        // WAIT_CYCLES=0 instance with requests held continuously valid
        for (int i = 0; i < N0; i++) begin
            if (i < 4) begin
                q_wr[i] = 1'b1; q_ad[i] = 32'(4 * i); q_be[i] = 4'hF;
            end else begin
                q_wr[i] = 1'($urandom);
                q_ad[i] = 32'(4 * $urandom_range(0, 3));
                q_be[i] = 4'($urandom);
                if (i == 7) q_ad[i] = q_ad[i] + 32'd2;
            end
            q_wd[i] = $urandom;
            model(1'b1, q_wr[i], q_ad[i], q_wd[i], q_be[i], q_erd[i], q_eer[i]);
        end
        @(negedge clk);
        idx = 0; ri = 0; e = 0; last_acc = -1; prev_v = 0;
        rw0 = q_wr[0]; ra0 = q_ad[0]; rwd0 = q_wd[0]; rbe0 = q_be[0]; rv0 = 1'b1;
        for (int c = 0; c < 100 && ri < N0; c++) begin
            acc_now = (rdy0 === 1'b1) && rv0;
            @(posedge clk);
            e++;
            if (acc_now) begin
                if (last_acc >= 0) check("w0_accept_spacing", 64'(e - last_acc), 64'd3);
                last_acc = e;
                idx++;
                #1;
                if (idx < N0) begin
                    rw0 = q_wr[idx]; ra0 = q_ad[idx]; rwd0 = q_wd[idx]; rbe0 = q_be[idx];
                end else begin
                    rv0 = 1'b0;
                end
            end
            @(negedge clk);
            if (vl0 === 1'b1) begin
                check("w0_rsp_timing", 64'(e), 64'(last_acc + 1));
                check("w0_ready_low_in_resp", 64'(rdy0), 64'd0);
                check("w0_pulse_single", 64'(prev_v), 64'd0);
                check("w0_rsp", {31'd0, er0, rd0}, {31'd0, q_eer[ri], q_erd[ri]});
                ri++;
            end else begin
                if (!(er0 === 1'b0 && rd0 === 32'd0)) check("w0_idle_outputs_zero", {31'd0, er0, rd0}, 64'd0);
            end
            prev_v = (vl0 === 1'b1);
        end
        check("w0_all_responses", 64'(ri), 64'(N0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
